// File: rtl/block_swap_tag_ctrl.sv
// Tag/lookup controller for the block-swap scratchpad: parallel per-port tag lookup,
// victim selection (round-robin or LRU) and one request/grant/done swap transaction per miss.
module block_swap_tag_ctrl #(
    parameter int NumPorts   = 2,
    parameter int NumSlots   = 4,
    parameter int AddrWidth  = 21,
    parameter int ReplPolicy = 0,
    parameter int CntWidth   = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 en_i,
    input  logic [NumPorts*AddrWidth-1:0]        req_addr_i,
    input  logic [NumPorts-1:0]                  req_valid_i,
    output logic [NumPorts-1:0]                  hit_o,
    output logic [NumPorts*$clog2(NumSlots)-1:0] slot_idx_o,
    output logic                                 block_o,
    output logic                                 swap_req_o,
    input  logic                                 swap_gnt_i,
    input  logic                                 swap_done_i,
    output logic [$clog2(NumSlots)-1:0]          swap_slot_o,
    output logic                                 swap_old_valid_o,
    output logic [AddrWidth-1:0]                 swap_old_addr_o,
    output logic [AddrWidth-1:0]                 swap_new_addr_o,
    output logic [CntWidth-1:0]                  miss_cnt_o
);

    localparam int SlotW = $clog2(NumSlots);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] BUSY = 2'd2;
    localparam logic [1:0] UPD  = 2'd3;

    logic [1:0]           state_r;
    logic [AddrWidth-1:0] tag_r [NumSlots];
    logic [NumSlots-1:0]  valid_r;
    logic [SlotW-1:0]     rr_ptr_r;
    logic [SlotW-1:0]     age_r [NumSlots];
    logic [SlotW-1:0]     victim_r;
    logic                 old_valid_r;
    logic [AddrWidth-1:0] old_addr_r;
    logic [AddrWidth-1:0] new_addr_r;
    logic [CntWidth-1:0]  miss_cnt_r;

    logic [NumPorts-1:0]       hit_s;
    logic [NumPorts-1:0]       miss_s;
    logic [NumPorts*SlotW-1:0] slot_idx_s;
    logic [AddrWidth-1:0]      new_addr_s;
    logic [SlotW-1:0]          oldest_s;
    logic [SlotW-1:0]          victim_s;
    logic                      acc_en_s;
    logic [SlotW-1:0]          hit_slot_s;
    logic [SlotW-1:0]          acc_slot_s;
    logic [SlotW-1:0]          age_nxt_s [NumSlots];
    logic                      flush_s;

    // Parallel tag lookup; descending scans let the lowest index win.
    always_comb begin
        hit_s      = {NumPorts{1'b0}};
        slot_idx_s = {(NumPorts*SlotW){1'b0}};
        new_addr_s = {AddrWidth{1'b0}};
        hit_slot_s = {SlotW{1'b0}};
        for (int p = 0; p < NumPorts; p++) begin
            for (int s = NumSlots - 1; s >= 0; s--) begin
                logic match_v;
                match_v = req_valid_i[p] & en_i & valid_r[s] &
                          (tag_r[s] == req_addr_i[p*AddrWidth +: AddrWidth]);
                hit_s[p] = hit_s[p] | match_v;
                slot_idx_s[p*SlotW +: SlotW] = match_v ? SlotW'(s) : slot_idx_s[p*SlotW +: SlotW];
            end
        end
        miss_s = req_valid_i & ~hit_s & {NumPorts{en_i}};
        for (int p = NumPorts - 1; p >= 0; p--) begin
            new_addr_s = miss_s[p] ? req_addr_i[p*AddrWidth +: AddrWidth] : new_addr_s;
            hit_slot_s = hit_s[p] ? slot_idx_s[p*SlotW +: SlotW] : hit_slot_s;
        end
    end

    // Victim choice: an empty slot always wins over the replacement policy.
    always_comb begin
        oldest_s = {SlotW{1'b0}};
        for (int s = NumSlots - 1; s >= 0; s--) begin
            oldest_s = (age_r[s] == SlotW'(NumSlots - 1)) ? SlotW'(s) : oldest_s;
        end
        victim_s = (ReplPolicy == 1) ? oldest_s : rr_ptr_r;
        for (int s = NumSlots - 1; s >= 0; s--) begin
            victim_s = valid_r[s] ? victim_s : SlotW'(s);
        end
    end

    // LRU ageing: the touched slot becomes youngest, younger slots shift up by one.
    always_comb begin
        acc_en_s   = (state_r == UPD) | (|hit_s);
        acc_slot_s = (state_r == UPD) ? victim_r : hit_slot_s;
        for (int s = 0; s < NumSlots; s++) begin
            age_nxt_s[s] = !acc_en_s                        ? age_r[s] :
                           (SlotW'(s) == acc_slot_s)        ? {SlotW{1'b0}} :
                           (age_r[s] < age_r[acc_slot_s])   ? age_r[s] + SlotW'(1) :
                                                              age_r[s];
        end
        flush_s = (state_r == IDLE) & ~en_i;
    end

    // Swap transaction FSM and the registered request fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            victim_r    <= {SlotW{1'b0}};
            old_valid_r <= 1'b0;
            old_addr_r  <= {AddrWidth{1'b0}};
            new_addr_r  <= {AddrWidth{1'b0}};
            miss_cnt_r  <= {CntWidth{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (|miss_s) begin
                        state_r     <= REQ;
                        victim_r    <= victim_s;
                        old_valid_r <= valid_r[victim_s];
                        old_addr_r  <= tag_r[victim_s];
                        new_addr_r  <= new_addr_s;
                        if (miss_cnt_r != {CntWidth{1'b1}}) begin
                            miss_cnt_r <= miss_cnt_r + CntWidth'(1);
                        end
                    end
                end
                REQ: begin
                    if (!en_i) begin
                        state_r <= IDLE;
                    end else if (swap_gnt_i) begin
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    if (swap_done_i) begin
                        state_r <= UPD;
                    end
                end
                UPD:     state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Tag store, valid bits, RR pointer and ages; flush only acts while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_r  <= {NumSlots{1'b0}};
            rr_ptr_r <= {SlotW{1'b0}};
            for (int s = 0; s < NumSlots; s++) begin
                tag_r[s] <= {AddrWidth{1'b0}};
                age_r[s] <= SlotW'(s);
            end
        end else begin
            if (state_r == UPD) begin
                tag_r[victim_r]   <= new_addr_r;
                valid_r[victim_r] <= 1'b1;
                rr_ptr_r          <= victim_r + SlotW'(1);
            end else if (flush_s) begin
                valid_r  <= {NumSlots{1'b0}};
                rr_ptr_r <= {SlotW{1'b0}};
            end
            for (int s = 0; s < NumSlots; s++) begin
                age_r[s] <= flush_s ? SlotW'(s) : age_nxt_s[s];
            end
        end
    end

    assign hit_o            = hit_s;
    assign slot_idx_o       = slot_idx_s;
    assign block_o          = (|miss_s) | (state_r != IDLE);
    assign swap_req_o       = (state_r == REQ);
    assign swap_slot_o      = victim_r;
    assign swap_old_valid_o = old_valid_r;
    assign swap_old_addr_o  = old_addr_r;
    assign swap_new_addr_o  = new_addr_r;
    assign miss_cnt_o       = miss_cnt_r;

endmodule

// File: tb/tb_block_swap_tag_ctrl.sv
// Directed bench: a round-robin and an LRU instance share stimulus and the swap handshake.
module tb_block_swap_tag_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic [41:0] req_addr_i = 42'd0;
    logic [1:0]  req_valid_i = 2'b00;
    logic        swap_gnt_i = 1'b0;
    logic        swap_done_i = 1'b0;

    logic [1:0]  rr_hit, lru_hit;
    logic [3:0]  rr_idx, lru_idx;
    logic        rr_blk, lru_blk, rr_req, lru_req, rr_ov, lru_ov;
    logic [1:0]  rr_slot, lru_slot;
    logic [20:0] rr_old, lru_old, rr_new, lru_new;
    logic [15:0] rr_cnt, lru_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    block_swap_tag_ctrl #(.ReplPolicy(0)) u_rr (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .req_addr_i(req_addr_i),
        .req_valid_i(req_valid_i), .hit_o(rr_hit), .slot_idx_o(rr_idx), .block_o(rr_blk),
        .swap_req_o(rr_req), .swap_gnt_i(swap_gnt_i), .swap_done_i(swap_done_i),
        .swap_slot_o(rr_slot), .swap_old_valid_o(rr_ov), .swap_old_addr_o(rr_old),
        .swap_new_addr_o(rr_new), .miss_cnt_o(rr_cnt)
    );

    block_swap_tag_ctrl #(.ReplPolicy(1)) u_lru (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .req_addr_i(req_addr_i),
        .req_valid_i(req_valid_i), .hit_o(lru_hit), .slot_idx_o(lru_idx), .block_o(lru_blk),
        .swap_req_o(lru_req), .swap_gnt_i(swap_gnt_i), .swap_done_i(swap_done_i),
        .swap_slot_o(lru_slot), .swap_old_valid_o(lru_ov), .swap_old_addr_o(lru_old),
        .swap_new_addr_o(lru_new), .miss_cnt_o(lru_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Waits for the request, checks both instances' fields, then grant and done one cycle apart.
    task automatic do_swap(input string tg,
                           input logic [1:0] rs, input logic rov, input logic [20:0] rold,
                           input logic [1:0] ls, input logic lov, input logic [20:0] lold,
                           input logic [20:0] nw, input logic [1:0] hmask, input logic blk);
        for (int i = 0; i < 20 && !rr_req; i++) tick();
        chk({tg, "_rr_req"}, rr_req, 1'b1);
        chk({tg, "_lru_req"}, lru_req, 1'b1);
        chk({tg, "_rr_slot"}, rr_slot, rs);
        chk({tg, "_rr_ov"}, rr_ov, rov);
        if (rov) chk({tg, "_rr_old"}, rr_old, rold);
        chk({tg, "_rr_new"}, rr_new, nw);
        chk({tg, "_lru_slot"}, lru_slot, ls);
        chk({tg, "_lru_ov"}, lru_ov, lov);
        if (lov) chk({tg, "_lru_old"}, lru_old, lold);
        chk({tg, "_lru_new"}, lru_new, nw);
        swap_gnt_i = 1'b1;
        tick();
        swap_gnt_i = 1'b0;
        swap_done_i = 1'b1;
        tick();
        swap_done_i = 1'b0;
        tick();
        chk({tg, "_rr_hit"}, rr_hit, hmask);
        chk({tg, "_lru_hit"}, lru_hit, hmask);
        chk({tg, "_rr_blk"}, rr_blk, blk);
        chk({tg, "_lru_blk"}, lru_blk, blk);
    endtask

    task automatic set_ports(input logic [20:0] a0, input logic [20:0] a1, input logic [1:0] v);
        req_addr_i  = {a1, a0};
        req_valid_i = v;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_req", rr_req, 1'b0);
        chk("rst_blk", rr_blk, 1'b0);
        chk("rst_cnt", rr_cnt, 16'd0);
        chk("rst_slot", lru_slot, 2'd0);
        rst_i = 1'b0;
        tick();

        // First miss with exact latency
        en_i = 1'b1;
        set_ports(21'h10, 21'h0, 2'b01);
        #1;
        chk("t1_blk", rr_blk, 1'b1);
        tick();
        chk("t1_req", rr_req, 1'b1);
        chk("t1_slot", rr_slot, 2'd0);
        chk("t1_ov", rr_ov, 1'b0);
        chk("t1_new", rr_new, 21'h10);
        swap_gnt_i = 1'b1;
        tick();
        swap_gnt_i = 1'b0;
        chk("t1_req_drop", rr_req, 1'b0);
        swap_done_i = 1'b1;
        tick();
        swap_done_i = 1'b0;
        tick();
        chk("t1_hit", rr_hit, 2'b01);
        chk("t1_idx", rr_idx[1:0], 2'd0);
        chk("t1_cnt", rr_cnt, 16'd1);
        chk("t1_blk_off", rr_blk, 1'b0);

        // Fill remaining empty slots
        set_ports(21'h11, 21'h0, 2'b01);
        do_swap("fill1", 2'd1, 1'b0, 21'h0, 2'd1, 1'b0, 21'h0, 21'h11, 2'b01, 1'b0);
        set_ports(21'h12, 21'h0, 2'b01);
        do_swap("fill2", 2'd2, 1'b0, 21'h0, 2'd2, 1'b0, 21'h0, 21'h12, 2'b01, 1'b0);
        set_ports(21'h13, 21'h0, 2'b01);
        do_swap("fill3", 2'd3, 1'b0, 21'h0, 2'd3, 1'b0, 21'h0, 21'h13, 2'b01, 1'b0);

        // Touch 0x10, then replacement: RR picks slot 0, LRU picks oldest slot 1
        set_ports(21'h10, 21'h0, 2'b01);
        #1;
        chk("t3_hit10", lru_hit, 2'b01);
        tick();
        set_ports(21'h20, 21'h0, 2'b01);
        do_swap("repl20", 2'd0, 1'b1, 21'h10, 2'd1, 1'b1, 21'h11, 21'h20, 2'b01, 1'b0);
        set_ports(21'h21, 21'h0, 2'b01);
        do_swap("repl21", 2'd1, 1'b1, 21'h11, 2'd2, 1'b1, 21'h12, 21'h21, 2'b01, 1'b0);

        // Two ports missing different addresses: two swaps, port0 first
        set_ports(21'h30, 21'h31, 2'b11);
        do_swap("dual30", 2'd2, 1'b1, 21'h12, 2'd3, 1'b1, 21'h13, 21'h30, 2'b01, 1'b1);
        do_swap("dual31", 2'd3, 1'b1, 21'h13, 2'd0, 1'b1, 21'h10, 21'h31, 2'b11, 1'b0);
        chk("t4_rr_idx", rr_idx, 4'b1110);
        chk("t4_lru_idx", lru_idx, 4'b0011);
        chk("t4_cnt", rr_cnt, 16'd8);

        // Same address on both ports: one swap only
        set_ports(21'h40, 21'h40, 2'b11);
        do_swap("same40", 2'd0, 1'b1, 21'h20, 2'd1, 1'b1, 21'h20, 21'h40, 2'b11, 1'b0);
        tick(); tick(); tick();
        chk("t4_same_noreq", rr_req, 1'b0);
        chk("t4_same_cnt", lru_cnt, 16'd9);

        // Withdraw in REQ, then flush
        set_ports(21'h50, 21'h0, 2'b01);
        tick();
        chk("t5_req", rr_req, 1'b1);
        en_i = 1'b0;
        tick();
        chk("t5_withdraw", rr_req, 1'b0);
        chk("t5_hit_off", rr_hit, 2'b00);
        tick();
        en_i = 1'b1;
        set_ports(21'h40, 21'h0, 2'b01);
        #1;
        chk("t5_rr_flushed", rr_hit, 2'b00);
        chk("t5_lru_flushed", lru_hit, 2'b00);
        chk("t5_blk", rr_blk, 1'b1);
        do_swap("refill", 2'd0, 1'b0, 21'h0, 2'd0, 1'b0, 21'h0, 21'h40, 2'b01, 1'b0);
        chk("t5_cnt", rr_cnt, 16'd11);

        // Disable in BUSY: block held until done, flush afterwards
        set_ports(21'h51, 21'h0, 2'b01);
        tick();
        swap_gnt_i = 1'b1;
        tick();
        swap_gnt_i = 1'b0;
        en_i = 1'b0;
        tick(); tick();
        chk("t5_busy_blk", rr_blk, 1'b1);
        swap_done_i = 1'b1;
        tick();
        swap_done_i = 1'b0;
        chk("t5_upd_blk", lru_blk, 1'b1);
        tick();
        chk("t5_idle_blk", rr_blk, 1'b0);
        tick();
        en_i = 1'b1;
        #1;
        chk("t5_busy_flushed", rr_hit, 2'b00);
        chk("t5_cnt2", rr_cnt, 16'd12);

        // Grant held off for 10 cycles with an early done pulse
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t6_hold_req", rr_req, 1'b1);
            chk("t6_hold_new", rr_new, 21'h51);
            chk("t6_hold_slot", rr_slot, 2'd0);
            swap_done_i = (i == 4);
            tick();
        end
        swap_done_i = 1'b0;
        chk("t6_still_req", rr_req, 1'b1);
        chk("t6_cnt", rr_cnt, 16'd13);
        swap_gnt_i = 1'b1;
        tick();
        swap_gnt_i = 1'b0;
        chk("t6_busy_noreq", rr_req, 1'b0);
        chk("t6_busy_blk", rr_blk, 1'b1);

        // Asynchronous reset mid-BUSY
        #2;
        rst_i = 1'b1;
        req_valid_i = 2'b00;
        #1;
        chk("t6_rst_blk", rr_blk, 1'b0);
        chk("t6_rst_cnt", rr_cnt, 16'd0);
        chk("t6_rst_new", rr_new, 21'h0);
        chk("t6_rst_slot", lru_slot, 2'd0);
        chk("t6_rst_req", lru_req, 1'b0);
        tick();
        rst_i = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
